// File: rtl/sprite_palette_arbiter.sv
// Round-robin arbiter sharing one sprite ROM and palette among NUM_REQ requesters; fixed latency 3.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module sprite_palette_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 10,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    output logic                      rom_rd_o,
    input  logic [IDX_W-1:0]          rom_index_i,
    output logic [IDX_W-1:0]          pal_index_o,
    input  logic [11:0]               pal_rgb_i,
    output logic                      rsp_valid_o,
    output logic [2:0]                rsp_id_o,
    output logic [11:0]               rsp_rgb_o,
    output logic                      rsp_transparent_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] TRANSP_KEY = IDX_W'(TRANSP_IDX);
    localparam logic [PTR_W:0]   NUM_REQ_W  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_ID    = PTR_W'(NUM_REQ - 1);

    logic [ADDR_W-1:0] req_addr_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    logic [PTR_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0] grant_vec;
    logic [PTR_W-1:0]   grant_id;
    logic               grant_any;
    logic [PTR_W:0]     cand;
    logic [PTR_W-1:0]   cand_ptr;

    // Walk the requesters starting at the pointer; the first asserted one wins.
    always_comb begin
        grant_vec = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        cand_ptr  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            cand_ptr = cand[PTR_W-1:0];
            if (!grant_any && req_valid_i[cand_ptr]) begin
                grant_vec[cand_ptr] = 1'b1;
                grant_id            = cand_ptr;
                grant_any           = 1'b1;
            end
        end
        if (flush_i) begin
            grant_vec = '0;
            grant_any = 1'b0;
        end
    end

    assign req_ready_o = grant_vec;

`ifdef ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

    // Stage 1 drives the ROM, stage 2 sees its data, the response register is stage 3.
    logic              rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [PTR_W-1:0]  s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    logic [PTR_W-1:0]  s2_id_q, s2_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [2:0]        rsp_id_q, rsp_id_d;
    logic [11:0]       rsp_rgb_q, rsp_rgb_d;
    logic              rsp_transp_q, rsp_transp_d;

    always_comb begin
        rom_rd_d     = grant_any;
        rom_addr_d   = rom_addr_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = rom_rd_q & ~flush_i;
        s2_id_d      = s2_id_q;
        rsp_valid_d  = s2_valid_q & ~flush_i;
        rsp_id_d     = rsp_id_q;
        rsp_rgb_d    = rsp_rgb_q;
        rsp_transp_d = rsp_transp_q;
        if (grant_any) begin
            rom_addr_d = req_addr_arr[grant_id];
            s1_id_d    = grant_id;
        end
        if (rom_rd_q) begin
            s2_id_d = s1_id_q;
        end
        if (s2_valid_q && !flush_i) begin
            rsp_id_d     = 3'(s2_id_q);
            rsp_rgb_d    = pal_rgb_i;
            rsp_transp_d = (rom_index_i == TRANSP_KEY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_rd_q     <= 1'b0;
            rom_addr_q   <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_rgb_q    <= '0;
            rsp_transp_q <= 1'b0;
        end else begin
            rom_rd_q     <= rom_rd_d;
            rom_addr_q   <= rom_addr_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_id_q      <= s2_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rgb_q    <= rsp_rgb_d;
            rsp_transp_q <= rsp_transp_d;
        end
    end

    assign rom_rd_o          = rom_rd_q;
    assign rom_addr_o        = rom_addr_q;
    assign pal_index_o       = rom_index_i;
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_id_o          = rsp_id_q;
    assign rsp_rgb_o         = rsp_rgb_q;
    assign rsp_transparent_o = rsp_transp_q;

    grant_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));

endmodule

// File: doc/sprite_palette_arbiter.md
Name: sprite_palette_arbiter

Overview:
- Shares one sprite ROM and one 16-entry palette lookup among NUM_REQ sprite requesters (tanks, bullets, battery icons).
- Arbitrates requests round-robin, sequences the synchronous ROM read, then returns registered 12-bit RGB plus a transparency flag and requester ID.
- Sits between the per-sprite draw logic and the pixel mux feeding the VGA output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, sprite ROM address width
- IDX_W, 4, palette index width
- TRANSP_IDX, 2, palette index treated as transparent (magenta key F0D)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all in-flight transactions
- req_valid  in  NUM_REQ  per-requester request
- req_addr  in  NUM_REQ*ADDR_W  per-requester ROM address; requester i at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid and rr pointer
- rom_addr  out  ADDR_W  registered ROM read address
- rom_rd  out  1  registered ROM read strobe
- rom_index  in  IDX_W  ROM data, valid one cycle after rom_rd
- pal_index  out  IDX_W  drives palette index (= rom_index, combinational)
- pal_rgb  in  12  palette output {R,G,B}, combinational from pal_index
- rsp_valid  out  1  response strobe, one cycle
- rsp_id  out  3  requester number of the response
- rsp_rgb  out  12  registered colour
- rsp_transparent  out  1  high when fetched index == TRANSP_IDX

Behaviour:
- Reset (Reset_n low, async): rr pointer=0; rom_addr=0, rom_rd=0, rsp_valid=0, rsp_id=0, rsp_rgb=0, rsp_transparent=0; all pipeline valid bits cleared. Reset mid-transaction loses it; no response follows.
- Grant: search req_valid starting at rr pointer, wrapping modulo NUM_REQ; first asserted bit gets req_ready. At most one req_ready high. None high if no req_valid. Handshake = req_valid[i] & req_ready[i].
- Pointer: on handshake with requester g, rr pointer <= (g+1) mod NUM_REQ; unchanged with no handshake.
- Pipeline, fixed latency 3, one accept per cycle, no backpressure:
  - Cycle N: handshake.
  - N+1: rom_addr=req_addr of g, rom_rd=1, id carried.
  - N+2: rom_index valid; pal_index=rom_index; capture pal_rgb and compare with TRANSP_IDX.
  - N+3: rsp_valid=1 with rsp_id=g, rsp_rgb, rsp_transparent.
- Back-to-back grants produce back-to-back responses in grant order. rom_rd and rsp_valid idle low. rom_addr/rsp_rgb/rsp_id hold last value when idle.
- flush: asserted in cycle F:
  - req_ready forced 0 in F.
  - All stage valid bits cleared at F's edge, so rom_rd and rsp_valid are 0 in F+1; no response from earlier grants appears after F.
  - rr pointer unchanged.
- A requester that keeps req_valid high after its handshake is treated as a new request.
- rsp_id width fixed at 3; upper bits are 0 when NUM_REQ<8.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: grant goes to lowest-numbered asserted req_valid; rr pointer is removed and held 0. Starvation of higher indices is acceptable.
- Undefined: round-robin as above.

Test Plan:
- Single request: req_valid=4'b0100, req_addr[2]=10'h05A, ROM index 3 at 0x05A, pal_rgb=12'hD72. Required: req_ready=4'b0100 at N; rom_rd=1, rom_addr=10'h05A at N+1; rsp_valid=1, rsp_id=2, rsp_rgb=12'hD72, rsp_transparent=0 at N+3.
- Fairness: all four req_valid held high for 8 cycles from reset. Required: grants 0,1,2,3,0,1,2,3. Eight consecutive responses with matching IDs, starting 3 cycles after the first grant.
- Transparency: ROM returns index 2 with pal_rgb=12'hF0D. Required: rsp_transparent=1, rsp_rgb=12'hF0D.
- Wrap pointer: grant requester 3, then only req_valid[1] high. Required: requester 1 granted next cycle; pointer becomes 2.
- Flush: three back-to-back grants, flush pulsed one cycle after the third. Required: no rsp_valid from cycle flush+1 onward; the next new request responds normally with latency 3.
- Async reset: Reset_n dropped mid-pipeline between clock edges. Required: rsp_valid, rom_rd=0 immediately; no response after release; first grant after release goes to requester 0.
- With ARB_FIXED_PRIO_EN: req_valid=4'b1010 held. Required: requester 1 granted every cycle; requester 3 never.
